// File: rtl/program_counter_unit.sv
// Program counter with trap/redirect priority, a deferred-redirect latch
// used while fetch is stalled (clk_gate=0), and a circular return-address
// stack for call/ret prediction.
module program_counter_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_gate,
  input  logic                             redir_valid,
  input  logic [XLEN-1:0]                  redir_target,
  input  logic                             trap_valid,
  input  logic [XLEN-1:0]                  trap_vector,
  input  logic                             call,
  input  logic                             ret,
  output logic [XLEN-1:0]                  PC,
  output logic                             redir_pending,
  output logic                             misaligned,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_underflow
);

  localparam int unsigned     CW       = $clog2(RAS_DEPTH + 1);
  localparam int unsigned     PW       = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0]   CNT_FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_TRAP,
    SRC_REDIR,
    SRC_PEND,
    SRC_RAS,
    SRC_SEQ
  } pc_src_e;

  logic [XLEN-1:0] pc_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic            misal_q;
  logic            undf_q;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   cnt_q;

  pc_src_e         src;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic [PW-1:0]   top_idx;
  logic            ras_empty;
  logic            seq_sel;
  logic            tgt_misaligned;
  logic            do_push;
  logic            do_pop;
  logic            do_replace;

  // Next-PC source selection in priority order, plus RAS operation decode.
  always_comb begin
    pc_plus4  = pc_q + XLEN'(4);
    top_idx   = wr_ptr_q - PW'(1);
    ras_empty = (cnt_q == '0);
    seq_sel   = clk_gate && !trap_valid && !redir_valid && !pend_q;
    src       = SRC_HOLD;
    raw_tgt   = pc_q;
    if (trap_valid) begin
      src     = SRC_TRAP;
      raw_tgt = trap_vector;
    end else if (clk_gate) begin
      if (redir_valid) begin
        src     = SRC_REDIR;
        raw_tgt = redir_target;
      end else if (pend_q) begin
        src     = SRC_PEND;
        raw_tgt = pend_tgt_q;
      end else if (ret && !ras_empty) begin
        src     = SRC_RAS;
        raw_tgt = ras_q[top_idx];
      end else begin
        src     = SRC_SEQ;
        raw_tgt = pc_plus4;
      end
    end
    next_pc        = {raw_tgt[XLEN-1:2], 2'b00};
    tgt_misaligned = ((src == SRC_TRAP) || (src == SRC_REDIR) || (src == SRC_PEND))
                     && (raw_tgt[1:0] != 2'b00);
    // call+ret on an empty stack behaves as a plain call (push)
    do_push    = seq_sel && call && (!ret || ras_empty);
    do_pop     = seq_sel && ret && !call && !ras_empty;
    do_replace = seq_sel && ret && call && !ras_empty;
  end

  // PC, deferred redirect latch and one-cycle status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      misal_q    <= 1'b0;
      undf_q     <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      misal_q <= tgt_misaligned;
      undf_q  <= seq_sel && ret && ras_empty;
      if (trap_valid) begin
        pend_q     <= 1'b0;
        pend_tgt_q <= '0;
      end else if (!clk_gate) begin
        if (redir_valid) begin
          pend_q     <= 1'b1;
          pend_tgt_q <= redir_target;
        end
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  // Circular return-address stack; a push when full overwrites the oldest slot,
  // which is exactly the slot the write pointer already addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_q    <= '{default: '0};
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (trap_valid) begin
      cnt_q <= '0;
    end else if (do_push) begin
      ras_q[wr_ptr_q] <= pc_plus4;
      wr_ptr_q        <= wr_ptr_q + PW'(1);
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      wr_ptr_q <= top_idx;
      cnt_q    <= cnt_q - CW'(1);
    end else if (do_replace) begin
      ras_q[top_idx] <= pc_plus4;
    end
  end

  assign PC            = pc_q;
  assign redir_pending = pend_q;
  assign misaligned    = misal_q;
  assign ras_count     = cnt_q;
  assign ras_underflow = undf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Randomized plus directed bench for program_counter_unit, compared against a
// queue-based behavioural model of the next-PC and return-stack rules.
module tb_program_counter_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_gate = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic        redir_pending;
  logic        misaligned;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  logic        g8 = 1'b0;
  logic [7:0]  pc8;
  logic        pend8, mis8, udf8;
  logic [1:0]  cnt8;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // behavioural reference state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_mis;
  logic        m_udf;
  logic [31:0] m_ras [$];

  always #5 clk = ~clk;

  program_counter_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_gate(clk_gate),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .call(call), .ret(ret),
    .PC(pc), .redir_pending(redir_pending), .misaligned(misaligned),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  program_counter_unit #(.XLEN(8), .RESET_VECTOR(8'hFC), .RAS_DEPTH(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clk_gate(g8),
    .redir_valid(1'b0), .redir_target(8'h00),
    .trap_valid(1'b0), .trap_vector(8'h00),
    .call(1'b0), .ret(1'b0),
    .PC(pc8), .redir_pending(pend8), .misaligned(mis8),
    .ras_count(cnt8), .ras_underflow(udf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 1'b0; m_ptgt = '0; m_mis = 1'b0; m_udf = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step(input logic g, input logic rv, input logic [31:0] rt,
                            input logic tv, input logic [31:0] tvec,
                            input logic c, input logic r);
    logic [31:0] seq, top;
    m_mis = 1'b0;
    m_udf = 1'b0;
    seq   = m_pc + 32'd4;
    if (tv) begin
      m_pc = tvec & ~32'd3; m_mis = (tvec[1:0] != 0); m_pend = 1'b0; m_ras.delete();
    end else if (!g) begin
      if (rv) begin m_pend = 1'b1; m_ptgt = rt; end
    end else if (rv) begin
      m_pc = rt & ~32'd3; m_mis = (rt[1:0] != 0); m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_ptgt & ~32'd3; m_mis = (m_ptgt[1:0] != 0); m_pend = 1'b0;
    end else if (r && m_ras.size() > 0) begin
      top = m_ras[$];
      if (c) m_ras[m_ras.size()-1] = seq;
      else void'(m_ras.pop_back());
      m_pc = top & ~32'd3;
    end else begin
      if (r) m_udf = 1'b1;
      if (c) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = seq;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pc"},   pc, m_pc);
    check({tag, "_pend"}, {31'b0, redir_pending}, {31'b0, m_pend});
    check({tag, "_mis"},  {31'b0, misaligned}, {31'b0, m_mis});
    check({tag, "_cnt"},  {29'b0, ras_count}, m_ras.size());
    check({tag, "_udf"},  {31'b0, ras_underflow}, {31'b0, m_udf});
  endtask

  task automatic tick(input string tag, input logic g, input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tvec, input logic c, input logic r);
    clk_gate = g; redir_valid = rv; redir_target = rt;
    trap_valid = tv; trap_vector = tvec; call = c; ret = r;
    @(posedge clk);
    #1;
    model_step(g, rv, rt, tv, tvec, c, r);
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_pc"},   pc, 32'h0);
    check({tag, "_pend"}, {31'b0, redir_pending}, 32'h0);
    check({tag, "_cnt"},  {29'b0, ras_count}, 32'h0);
    check({tag, "_mis"},  {31'b0, misaligned}, 32'h0);
    check({tag, "_udf"},  {31'b0, ras_underflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pushed [5];
    logic [31:0] rt;
    int unsigned sel;

    // power-on reset applied between edges
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_pend", {31'b0, redir_pending}, 32'h0);
    check("rst_cnt", {29'b0, ras_count}, 32'h0);
    check("rst8_pc", {24'b0, pc8}, 32'hFC);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit instance: 0xFC wraps to 0x00
    g8 = 1'b1;
    @(posedge clk); #1;
    check("wrap8_a", {24'b0, pc8}, 32'h00);
    @(posedge clk); #1;
    check("wrap8_b", {24'b0, pc8}, 32'h04);
    g8 = 1'b0;
    // main DUT held with clk_gate=0 during those two edges; model unchanged

    // sequential fetch from reset
    tick("seq1", 1, 0, 0, 0, 0, 0, 0); check("seq1_abs", pc, 32'h4);
    tick("seq2", 1, 0, 0, 0, 0, 0, 0);
    tick("seq3", 1, 0, 0, 0, 0, 0, 0); check("seq3_abs", pc, 32'hC);

    // deferred redirect with overwrite
    tick("pend1", 0, 1, 32'h100, 0, 0, 0, 0); check("pend1_abs", {31'b0, redir_pending}, 32'h1);
    tick("pend2", 0, 1, 32'h204, 0, 0, 0, 0); check("pend2_pc", pc, 32'hC);
    tick("pend3", 1, 0, 0, 0, 0, 0, 0);       check("pend3_abs", pc, 32'h204);

    // trap beats redirect while gated
    tick("trpA", 1, 0, 0, 0, 0, 1, 0);
    tick("trp", 0, 1, 32'h300, 1, 32'h80, 0, 0);
    check("trp_abs", pc, 32'h80);
    check("trp_cnt", {29'b0, ras_count}, 32'h0);

    // call / redirect / ret / ret-underflow
    tick("cr0", 1, 1, 32'h10, 0, 0, 0, 0);
    tick("cr1", 1, 0, 0, 0, 0, 1, 0);      check("cr1_abs", pc, 32'h14);
    tick("cr2", 1, 1, 32'h400, 0, 0, 0, 0);
    tick("cr3", 1, 0, 0, 0, 0, 0, 1);      check("cr3_abs", pc, 32'h14);
    tick("cr4", 1, 0, 0, 0, 0, 0, 1);      check("cr4_udf", {31'b0, ras_underflow}, 32'h1);
    tick("cr5", 0, 0, 0, 0, 0, 0, 0);

    // overflow: 5 calls, 4 rets newest first
    for (int i = 0; i < 5; i++) begin
      pushed[i] = pc + 32'd4;
      tick("ovf_call", 1, 0, 0, 0, 0, 1, 0);
    end
    check("ovf_cnt", {29'b0, ras_count}, 32'd4);
    for (int i = 4; i >= 1; i--) begin
      tick("ovf_ret", 1, 0, 0, 0, 0, 0, 1);
      check("ovf_ret_abs", pc, pushed[i]);
    end
    tick("mis1", 1, 1, 32'h103, 0, 0, 0, 0); check("mis1_abs", pc, 32'h100);
    tick("mis2", 1, 0, 0, 0, 0, 0, 0);

    // 32-bit wrap
    tick("w32a", 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    tick("w32b", 1, 0, 0, 0, 0, 0, 0);       check("w32_abs", pc, 32'h0);

    // async reset with pending redirect and 3 RAS entries
    for (int i = 0; i < 3; i++) tick("ar_call", 1, 0, 0, 0, 0, 1, 0);
    tick("ar_pend", 0, 1, 32'h500, 0, 0, 0, 0);
    check("ar_pre_cnt", {29'b0, ras_count}, 32'd3);
    async_reset("ar");
    tick("ar_post", 1, 0, 0, 0, 0, 0, 0);    check("ar_post_abs", pc, 32'h4);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(99);
      rt  = $urandom;
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      if (sel < 1) begin
        async_reset("rnd_rst");
      end else begin
        tick("rnd", ($urandom_range(3) != 0), ($urandom_range(9) == 0), rt,
             ($urandom_range(39) == 0), {$urandom} ^ {30'b0, 2'($urandom_range(3))},
             ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
